condlogic_it: RTL and testbench

Parametrised conditional-execution unit for the ARM datapath. It holds per-thread NZCV flag registers and evaluates the 4-bit condition field, gating register, memory, PC and flag writes. It adds a Thumb-2-style IT-block sequencer that supplies the condition for up to IT_MAX following instructions of the same thread. It sits in the Execute stage between the decoder's write requests and the register file, memory and PC muxes.

---
 rtl/condlogic_it.sv | 121 ++++++++++++
 tb/tb_condlogic_it.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_it.sv
// Conditional-execution unit: per-thread NZCV flags, ARM condition decode,
// gated write enables and a per-thread IT-block slot sequencer.
module condlogic_it #(
  parameter  int NTHREADS = 2,
  parameter  int IT_MAX   = 4,
  localparam int TW       = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
  localparam int LW       = $clog2(IT_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          InstrValid,
  input  logic          Stall,
  input  logic [TW-1:0] Tid,
  input  logic [3:0]    Cond,
  input  logic [3:0]    ALUFlags,
  input  logic [1:0]    FlagW,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          ITStart,
  input  logic [3:0]    ITFirstCond,
  input  logic [LW-1:0] ITLen,
  input  logic [IT_MAX-1:0] ITThen,
  output logic          CondEx,
  output logic          PCSrc,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          InIT,
  output logic [3:0]    FlagsOut
);

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  localparam logic [LW-1:0] MAX_LEN = LW'(IT_MAX);

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (cond_e'(c))
      C_EQ:    cond_pass = z;
      C_NE:    cond_pass = ~z;
      C_CS:    cond_pass = cy;
      C_CC:    cond_pass = ~cy;
      C_MI:    cond_pass = n;
      C_PL:    cond_pass = ~n;
      C_VS:    cond_pass = v;
      C_VC:    cond_pass = ~v;
      C_HI:    cond_pass = cy & ~z;
      C_LS:    cond_pass = ~cy | z;
      C_GE:    cond_pass = (n == v);
      C_LT:    cond_pass = (n != v);
      C_GT:    cond_pass = ~z & (n == v);
      C_LE:    cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  logic [3:0]    r_flags [NTHREADS];
  logic [LW-1:0] r_itcnt [NTHREADS];
  logic [3:0]    r_itq   [NTHREADS][IT_MAX];

  logic [TW-1:0] w_tid;
  logic          w_commit;
  logic          w_in_it;
  logic [3:0]    w_eff;
  logic [LW-1:0] w_len;
  logic [3:0]    w_slot [IT_MAX];

  always_comb begin
    // Out-of-range thread ids alias onto thread 0
    w_tid    = (int'(Tid) < NTHREADS) ? Tid : '0;
    w_commit = InstrValid & ~Stall & ~reset;
    w_in_it  = (r_itcnt[w_tid] != '0);
    w_eff    = w_in_it ? r_itq[w_tid][0] : Cond;
    w_len    = (ITLen > MAX_LEN) ? MAX_LEN : ITLen;
    for (int unsigned i = 0; i < IT_MAX; i++)
      w_slot[i] = (i == 0 || ITThen[i]) ? ITFirstCond : (ITFirstCond ^ 4'b0001);
  end

  always_comb begin
    CondEx   = cond_pass(w_eff, r_flags[w_tid]);
    RegWrite = RegW & CondEx & w_commit;
    MemWrite = MemW & CondEx & w_commit;
    PCSrc    = PCS  & CondEx & w_commit;
    InIT     = w_in_it;
    FlagsOut = r_flags[w_tid];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        r_flags[t] <= '0;
        r_itcnt[t] <= '0;
        for (int unsigned s = 0; s < IT_MAX; s++)
          r_itq[t][s] <= '0;
      end
    end else if (w_commit) begin
      if (CondEx) begin
        if (FlagW[1]) r_flags[w_tid][3:2] <= ALUFlags[3:2];
        if (FlagW[0]) r_flags[w_tid][1:0] <= ALUFlags[1:0];
      end
      if (w_in_it) begin
        // A taken branch abandons the rest of the block
        r_itcnt[w_tid] <= PCSrc ? '0 : (r_itcnt[w_tid] - LW'(1));
        for (int unsigned s = 0; s + 1 < IT_MAX; s++)
          r_itq[w_tid][s] <= r_itq[w_tid][s+1];
        r_itq[w_tid][IT_MAX-1] <= '0;
      end else if (ITStart && CondEx && (w_len != '0)) begin
        r_itcnt[w_tid] <= w_len;
        for (int unsigned s = 0; s < IT_MAX; s++)
          r_itq[w_tid][s] <= w_slot[s];
      end
    end
  end

endmodule

// File: tb/tb_condlogic_it.sv
// Directed-vector bench for condlogic_it (NTHREADS=2, IT_MAX=4).
module tb_condlogic_it;

  logic       clk = 1'b0;
  logic       reset;
  logic       InstrValid, Stall;
  logic [0:0] Tid;
  logic [3:0] Cond, ALUFlags, ITFirstCond, ITThen;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, ITStart;
  logic [2:0] ITLen;
  logic       CondEx, PCSrc, RegWrite, MemWrite, InIT;
  logic [3:0] FlagsOut;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  condlogic_it #(.NTHREADS(2), .IT_MAX(4)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Stall(Stall),
    .Tid(Tid), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .ITStart(ITStart),
    .ITFirstCond(ITFirstCond), .ITLen(ITLen), .ITThen(ITThen),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .InIT(InIT), .FlagsOut(FlagsOut)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic tid, input logic [3:0] c, input logic rw, input logic mw,
                       input logic pc, input logic [1:0] fw, input logic [3:0] alu);
    InstrValid = 1'b1; Stall = 1'b0; Tid = tid; Cond = c;
    RegW = rw; MemW = mw; PCS = pc; FlagW = fw; ALUFlags = alu;
    ITStart = 1'b0; ITFirstCond = 4'h0; ITLen = 3'd0; ITThen = 4'h0;
    #1;
  endtask

  task automatic drive_it(input logic tid, input logic [3:0] c, input logic [3:0] first,
                          input logic [2:0] len, input logic [3:0] thn);
    InstrValid = 1'b1; Stall = 1'b0; Tid = tid; Cond = c;
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00; ALUFlags = 4'h0;
    ITStart = 1'b1; ITFirstCond = first; ITLen = len; ITThen = thn;
    #1;
  endtask

  task automatic next;
    @(negedge clk);
  endtask

  logic [3:0] tbl_cond [12] = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'h9,
                                4'hA, 4'hB, 4'hC, 4'hD, 4'h5, 4'hF};
  logic       tbl_exp  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'hE, 1'b1, 1'b1, 1'b1, 2'b00, 4'h0);
    next;
    #1;
    check("rst_condex", CondEx, 1'b1);
    check("rst_regw", RegWrite, 1'b0);
    check("rst_memw", MemWrite, 1'b0);
    check("rst_pcsrc", PCSrc, 1'b0);
    check("rst_flags", FlagsOut, 4'h0);
    check("rst_init", InIT, 1'b0);
    next;
    reset = 1'b0;

    // EQ with Z=0 fails
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("eq_z0_condex", CondEx, 1'b0);
    check("eq_z0_regw", RegWrite, 1'b0);
    next;
    // IT instruction whose own condition fails must not open a block
    drive_it(1'b0, 4'h0, 4'hE, 3'd2, 4'hF);
    check("it_fail_condex", CondEx, 1'b0);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b11, 4'h4);
    check("it_fail_init", InIT, 1'b0);
    check("nobypass_flags", FlagsOut, 4'h0);
    check("al_regw", RegWrite, 1'b1);
    next;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("flags_upd", FlagsOut, 4'h4);
    check("eq_z1_regw", RegWrite, 1'b1);
    next;

    // IT EQ, len 3, then-mask 101 -> slots EQ, NE, EQ
    drive_it(1'b0, 4'hE, 4'h0, 3'd3, 4'b0101);
    check("it1_init_pre", InIT, 1'b0);
    check("it1_condex", CondEx, 1'b1);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("it1_s0_regw", RegWrite, 1'b1);
    check("it1_s0_init", InIT, 1'b1);
    next;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'hE, 1'b1, 1'b1, 1'b0, 2'b00, 4'h0);
      Stall = 1'b1; #1;
      check("stall_regw", RegWrite, 1'b0);
      check("stall_memw", MemWrite, 1'b0);
      check("stall_init", InIT, 1'b1);
      next;
    end
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("it1_s1_regw", RegWrite, 1'b0);
    check("it1_s1_init", InIT, 1'b1);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("it1_s2_regw", RegWrite, 1'b1);
    check("it1_s2_init", InIT, 1'b1);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("it1_post_regw", RegWrite, 1'b1);
    check("it1_post_init", InIT, 1'b0);
    next;

    // Thread 0 block (EQ, NE) interleaved with thread 1
    drive_it(1'b0, 4'hE, 4'h0, 3'd2, 4'b0001);
    next;
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("t1_eq_regw", RegWrite, 1'b0);
    check("t1_init", InIT, 1'b0);
    check("t1_flags", FlagsOut, 4'h0);
    next;
    drive(1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 2'b10, 4'h8);
    check("t1_ne_regw", RegWrite, 1'b1);
    next;
    drive(1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("t0_s0_regw", RegWrite, 1'b1);
    check("t0_s0_init", InIT, 1'b1);
    check("t0_flags", FlagsOut, 4'h4);
    next;
    drive(1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("t1_mi_flags", FlagsOut, 4'h8);
    check("t1_mi_regw", RegWrite, 1'b1);
    check("t1_mi_init", InIT, 1'b0);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("t0_s1_regw", RegWrite, 1'b0);
    check("t0_s1_init", InIT, 1'b1);
    next;
    drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("t0_done_init", InIT, 1'b0);
    check("t0_done_regw", RegWrite, 1'b1);
    next;

    // Taken branch in slot 0 of a 4-slot EQ block exits the block
    drive_it(1'b0, 4'hE, 4'h0, 3'd4, 4'hF);
    next;
    drive(1'b0, 4'h1, 1'b0, 1'b0, 1'b1, 2'b00, 4'h0);
    check("br_pcsrc", PCSrc, 1'b1);
    check("br_init", InIT, 1'b1);
    next;
    drive(1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("br_after_init", InIT, 1'b0);
    check("br_after_condex", CondEx, 1'b0);
    check("br_after_regw", RegWrite, 1'b0);
    next;

    // Reset mid-block with flags 1111
    drive(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF);
    next;
    drive_it(1'b0, 4'hE, 4'hE, 3'd4, 4'hF);
    next;
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
      next;
    end
    drive(1'b0, 4'hE, 1'b1, 1'b1, 1'b1, 2'b00, 4'h0);
    check("pre_rst_flags", FlagsOut, 4'hF);
    check("pre_rst_init", InIT, 1'b1);
    reset = 1'b1; #1;
    check("mid_rst_regw", RegWrite, 1'b0);
    check("mid_rst_memw", MemWrite, 1'b0);
    check("mid_rst_pcsrc", PCSrc, 1'b0);
    next;
    reset = 1'b0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
    check("post_rst_flags", FlagsOut, 4'h0);
    check("post_rst_init", InIT, 1'b0);
    check("post_rst_condex", CondEx, 1'b0);
    next;

    // Over-long ITLen clamps to 4 slots
    drive_it(1'b0, 4'hE, 4'hE, 3'd7, 4'hF);
    next;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'hE, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
      check("clamp_init", InIT, (k < 4) ? 1'b1 : 1'b0);
      next;
    end

    // Condition decode table on thread 1 with N=1 Z=0 C=0 V=1
    drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 2'b11, 4'h9);
    next;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, tbl_cond[k], 1'b1, 1'b0, 1'b0, 2'b00, 4'h0);
      InstrValid = 1'b0; #1;
      check($sformatf("decode_%0h", tbl_cond[k]), CondEx, tbl_exp[k]);
      check("inval_regw", RegWrite, 1'b0);
      next;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
